fc_argmax: RTL
==============

// Module: fc_argmax
// PURPOSE
//  Classifier stage directly downstream of the final fully-connected neurons.
//  Collects NUM_CLASSES signed FC scores (38-bit, fc11 output format) serially
//  via valid/ready, buffers them, then sequentially scans for the maximum.
//  Reports the winning class index and score with a one-cycle done pulse.
// PARAMETERS
//  NUM_CLASSES  10  number of FC output neurons / class scores per inference
//  DW           38  signed score width (matches FC accumulator output)
//  IDX_W        4   class index width, = $clog2(NUM_CLASSES), min 1
// PORTS
//  clk          in   1        rising-edge clock
//  rst_n        in   1        reset, asynchronous, active-low
//  start        in   1        begin new inference; sampled only in IDLE
//  score_in     in   DW       signed FC score, class order 0..NUM_CLASSES-1
//  score_valid  in   1        score_in valid
//  score_ready  out  1        block accepts score this cycle
//  busy         out  1        high in LOAD, SCAN, DONE
//  class_idx    out  IDX_W    index of maximum score
//  class_score  out  DW       maximum score value (signed)
//  done         out  1        one-cycle pulse, results valid
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; score_ready=0, busy=0, done=0,
//   class_idx=0, class_score=0; count/buffer cleared. Reset mid-LOAD/SCAN aborts.
//  States: IDLE -> LOAD -> SCAN -> DONE -> IDLE. All outputs registered.
//  IDLE: start=1 -> LOAD, cnt<=0. score_valid ignored in IDLE.
//  LOAD: score_ready=1. Handshake = score_valid & score_ready; writes buf[cnt],
//   cnt++. Handshake on cnt==NUM_CLASSES-1 -> SCAN; score_ready low the next
//   cycle. No handshake -> stay, no timeout.
//  SCAN: best<=buf[0], bidx<=0 on entry; one compare per cycle for i=1..N-1.
//   Replace only if buf[i] > best (signed, full DW). Ties keep lower index.
//   Takes NUM_CLASSES-1 cycles. NUM_CLASSES==1: SCAN skipped, LOAD -> DONE.
//  DONE: class_idx/class_score updated, done=1 for exactly one cycle, -> IDLE.
//  Latency: done high NUM_CLASSES cycles after the edge accepting last score.
//  class_idx/class_score hold until the next DONE; not cleared by start.
//  start while busy: ignored. start and done same cycle: ignored.
//  No arithmetic growth; compare only. Negative scores are valid.
// STRUCTURE
//  Package fc_pkg: FC_DW=38, FC_NUM_CLASSES=10, FC_IDX_W, state enum
//   {S_IDLE,S_LOAD,S_SCAN,S_DONE}, typedef signed [FC_DW-1:0] fc_score_t.
//  One sub-module: fc_score_buf, NUM_CLASSES x DW register file, one write
//   port (we, waddr, wdata), one combinational read port (raddr->rdata),
//   async-cleared by rst_n. FSM, counter and compare stay in fc_argmax.
// TESTING
//  1 scores {5,-3,12,7,0,1,2,3,4,6} -> class_idx=2, class_score=12, done 1 cycle.
//  2 all scores = -100 -> class_idx=0 (tie rule), class_score=-100.
//  3 max at last slot: score[9]=2^37-1, others -2^37 -> class_idx=9; signed
//    extremes compare correctly.
//  4 score_valid toggling 1/0 each cycle; start pulsed while busy -> same
//    result as back-to-back feed, exactly 10 handshakes, start ignored.
//  5 rst_n low after 4 accepted scores -> all outputs 0 immediately; fresh
//    start + 10 scores gives correct result with no stale data.
//  6 latency: done exactly 10 cycles after last handshake edge; score_ready
//    low from the cycle after last accept until the next LOAD.

Source files
------------

// File: rtl/fc_argmax_pkg.sv
// rtl/fc_argmax_pkg.sv - shared constants, state encoding and score type for the argmax classifier
package fc_pkg;

  localparam int FC_DW          = 38;
  localparam int FC_NUM_CLASSES = 10;
  localparam int FC_IDX_W       = (FC_NUM_CLASSES > 1) ? $clog2(FC_NUM_CLASSES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SCAN,
    S_DONE
  } fc_state_e;

  typedef logic signed [FC_DW-1:0] fc_score_t;

endpackage

// File: rtl/fc_argmax_if.sv
// rtl/fc_argmax_if.sv - score stream, control and result bundle between producer and argmax stage
interface fc_argmax_if
  import fc_pkg::*;
#(
  parameter int DW    = FC_DW,
  parameter int IDX_W = FC_IDX_W
) ();

  logic             start;
  logic [DW-1:0]    score_in;
  logic             score_valid;
  logic             score_ready;
  logic             busy;
  logic [IDX_W-1:0] class_idx;
  logic [DW-1:0]    class_score;
  logic             done;

  modport master (
    output start, score_in, score_valid,
    input  score_ready, busy, class_idx, class_score, done
  );

  modport slave (
    input  start, score_in, score_valid,
    output score_ready, busy, class_idx, class_score, done
  );

endinterface

// File: rtl/fc_argmax_score_buf.sv
// rtl/fc_argmax_score_buf.sv - class score register file, one write port, one combinational read port
module fc_score_buf
  import fc_pkg::*;
#(
  parameter int NUM_CLASSES = FC_NUM_CLASSES,
  parameter int DW          = FC_DW,
  parameter int IDX_W       = FC_IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [DW-1:0]    wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [DW-1:0]    rdata
);

  logic [DW-1:0] mem_q [NUM_CLASSES];

  // Write one score per accepted handshake; reset wipes every entry so no stale class survives an abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we && (32'(waddr) < NUM_CLASSES)) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = (32'(raddr) < NUM_CLASSES) ? mem_q[raddr] : '0;

endmodule

// File: rtl/fc_argmax.sv
// rtl/fc_argmax.sv - collects class scores serially, scans for the maximum, reports index and score
module fc_argmax
  import fc_pkg::*;
#(
  parameter int NUM_CLASSES = FC_NUM_CLASSES,
  parameter int DW          = FC_DW,
  parameter int IDX_W       = FC_IDX_W
) (
  input  logic        clk,
  input  logic        rst_n,
  fc_argmax_if.slave  bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);
  localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);

  fc_state_e               state_q, state_d;
  logic [IDX_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        bidx_q, bidx_d;
  logic [IDX_W-1:0]        class_idx_q, class_idx_d;
  logic signed [DW-1:0]    best_q, best_d;
  logic signed [DW-1:0]    class_score_q, class_score_d;
  logic signed [DW-1:0]    rdata;
  logic                    ready_q, ready_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    hs;

  // ready_q is only ever high in LOAD, so this is also the buffer write strobe
  assign hs = bus.score_valid & ready_q;

  fc_score_buf #(
    .NUM_CLASSES (NUM_CLASSES),
    .DW          (DW),
    .IDX_W       (IDX_W)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (hs),
    .waddr (cnt_q),
    .wdata (bus.score_in),
    .raddr (cnt_q),
    .rdata (rdata)
  );

  // Next-state logic: load scores, seed the running best from score 0, then one signed compare per cycle
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    best_d        = best_q;
    bidx_d        = bidx_q;
    class_idx_d   = class_idx_q;
    class_score_d = class_score_q;
    done_d        = 1'b0;
    case (state_q)
      S_IDLE: begin
        // the done cycle is spent in IDLE, and a start coinciding with it is dropped
        if (bus.start && !done_q) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        if (hs) begin
          if (cnt_q == '0) begin
            best_d = bus.score_in;
            bidx_d = '0;
          end
          if (cnt_q == LAST_IDX) begin
            state_d = (NUM_CLASSES == 1) ? S_DONE : S_SCAN;
            cnt_d   = ONE;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      S_SCAN: begin
        // strict greater-than keeps the lower index on ties
        if (rdata > best_q) begin
          best_d = rdata;
          bidx_d = cnt_q;
        end
        if (cnt_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_DONE: begin
        state_d       = S_IDLE;
        done_d        = 1'b1;
        class_idx_d   = bidx_q;
        class_score_d = best_q;
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_LOAD);
    busy_d  = (state_d != S_IDLE);
  end

  // State and registered outputs; reset aborts any inference in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      best_q        <= '0;
      bidx_q        <= '0;
      class_idx_q   <= '0;
      class_score_q <= '0;
      ready_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      best_q        <= best_d;
      bidx_q        <= bidx_d;
      class_idx_q   <= class_idx_d;
      class_score_q <= class_score_d;
      ready_q       <= ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign bus.score_ready = ready_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.class_idx   = class_idx_q;
  assign bus.class_score = class_score_q;

endmodule
